// File: rtl/burst_memory_if.sv
// burst_memory_if: request/response bundle between a fetch/data master and
// the burst_memory model. The master drives the request fields; the memory
// drives busy, read data, the read strobe and the reject pulse.
interface burst_memory_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] data_in;
    logic [1:0]            access_size;
    logic                  rw;
    logic                  enable;
    logic                  busy;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  error;

    // Request side: the master raises enable with address/rw/access_size.
    modport master (
        output address, data_in, access_size, rw, enable,
        input  busy, data_out, data_valid, error
    );

    // Memory side.
    modport slave (
        input  address, data_in, access_size, rw, enable,
        output busy, data_out, data_valid, error
    );
endinterface

// File: rtl/burst_memory.sv
// burst_memory: byte-addressable big-endian memory model with a registered
// single/4/8/16-word burst engine and a synchronous active-high reset.
//
// Optional feature macro: BURST_WRAP_EN
//   defined   -> critical-word-first wrapping bursts; range check only tests
//                that the start offset is inside the storage.
//   undefined -> incrementing bursts with a full end-of-range check.
//
// Handshake: a request (enable=1) is taken at a rising edge only while the
// engine is idle (busy=0 in that cycle); while busy=1 every request field
// is ignored. Read beats are qualified by data_valid (one beat per cycle, no
// backpressure). Write beats are taken from data_in at the accept edge and at
// each following edge while busy=1. A rejected request pulses error for one
// cycle and leaves the engine idle. o_dbg_state mirrors the FSM state
// (0=IDLE, 1=RD, 2=WR) for observation.
//
// WORD_BYTES is assumed to be a power of two.
module burst_memory #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DEPTH_BYTES = 1048576,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR  = ADDR_WIDTH'(32'h80020000)
) (
    input  logic             clock,
    input  logic             reset,
    burst_memory_if.slave    bus,
    output logic [1:0]       o_dbg_state
);

    localparam int WORD_BYTES = DATA_WIDTH / 8;
    localparam int MIDX       = $clog2(DEPTH_BYTES);
    localparam int AW1        = ADDR_WIDTH + 1;

    localparam logic [AW1-1:0]        LP_DEPTH   = AW1'(DEPTH_BYTES);
    localparam logic [ADDR_WIDTH-1:0] LP_ALIGN_M = ~ADDR_WIDTH'(WORD_BYTES - 1);
    localparam logic [MIDX-1:0]       LP_WB      = MIDX'(WORD_BYTES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_t;

    // Storage: intentionally never reset.
    logic [7:0] r_mem [0:DEPTH_BYTES-1];

    // Engine state.
    state_t                r_state;
    logic [MIDX-1:0]       r_off0;      // word-aligned start offset of the burst
    logic [4:0]            r_len;       // burst length in words (1/4/8/16)
    logic [4:0]            r_beat;      // index of the next beat to move
    logic                  r_busy;
    logic                  r_data_valid;
    logic                  r_error;
    logic [DATA_WIDTH-1:0] r_data_out;

    // Request decode.
    logic [ADDR_WIDTH-1:0] w_req_raw;
    logic [ADDR_WIDTH-1:0] w_req_off;
    logic [4:0]            w_req_len;
    logic                  w_req_bad;
    logic                  w_accept;

    // Beat addressing and data paths.
    logic [MIDX-1:0]       w_step;
    logic [MIDX-1:0]       w_beat_off;
    logic [MIDX-1:0]       w_acc_off;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic                  w_wr_en;

    // Offset relative to the storage base, modulo 2^ADDR_WIDTH, so addresses
    // below START_ADDR wrap to huge offsets and fail the range check.
    assign w_req_raw = bus.address - START_ADDR;
    assign w_req_off = w_req_raw & LP_ALIGN_M;

    // Burst length decode from access_size.
    always_comb begin
        w_req_len = 5'd1;
        case (bus.access_size)
            2'b00:   w_req_len = 5'd1;
            2'b01:   w_req_len = 5'd4;
            2'b10:   w_req_len = 5'd8;
            default: w_req_len = 5'd16;
        endcase
    end

`ifdef BURST_WRAP_EN
    // Wrapping bursts stay inside their own aligned block, so only the start
    // offset needs to be inside the storage.
    assign w_req_bad = ({1'b0, w_req_off} >= LP_DEPTH);
`else
    logic [AW1-1:0] w_req_end;

    // Incrementing bursts must also end inside the storage.
    assign w_req_end = {1'b0, w_req_off} + (AW1'(w_req_len) * AW1'(WORD_BYTES));
    assign w_req_bad = ({1'b0, w_req_off} >= LP_DEPTH) || (w_req_end > LP_DEPTH);
`endif

    assign w_accept = (r_state == ST_IDLE) && bus.enable;

    assign w_step = MIDX'(r_beat) * LP_WB;

`ifdef BURST_WRAP_EN
    logic [MIDX-1:0] w_span;
    logic [MIDX-1:0] w_mask;

    // Critical word first: the beat offset walks forward from the start word
    // and wraps inside the block of L words that contains it. The block base
    // is aligned to the span, so the wrap reduces to a mask.
    assign w_span     = MIDX'(r_len) * LP_WB;
    assign w_mask     = w_span - MIDX'(1);
    assign w_beat_off = (r_off0 & ~w_mask) | ((r_off0 + w_step) & w_mask);
`else
    assign w_beat_off = r_off0 + w_step;
`endif

    // When idle, the access (if any) is beat 0 of the incoming request;
    // otherwise it is the current beat of the running burst.
    assign w_acc_off = (r_state == ST_IDLE) ? w_req_off[MIDX-1:0] : w_beat_off;

    // Big-endian word assembly: lowest byte address lands in the MSBs.
    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < WORD_BYTES; i++) begin
            w_rd_data[DATA_WIDTH-1-8*i -: 8] = r_mem[w_acc_off + MIDX'(i)];
        end
    end

    // A write beat happens at the accept edge of a write and at every edge
    // spent in WR; reset at that edge suppresses it.
    assign w_wr_en = !reset &&
                     ((w_accept && !w_req_bad && bus.rw) || (r_state == ST_WR));

    // Storage write port, same byte order as the read path.
    always_ff @(posedge clock) begin
        if (w_wr_en) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                r_mem[w_acc_off + MIDX'(i)] <= bus.data_in[DATA_WIDTH-1-8*i -: 8];
            end
        end
    end

    // Burst FSM with registered busy/data_valid/error/data_out.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_off0       <= '0;
            r_len        <= 5'd1;
            r_beat       <= 5'd0;
            r_busy       <= 1'b0;
            r_data_valid <= 1'b0;
            r_error      <= 1'b0;
            r_data_out   <= '0;
        end else begin
            r_error <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_data_valid <= 1'b0;
                    if (w_accept) begin
                        if (w_req_bad) begin
                            r_error <= 1'b1;
                        end else begin
                            r_off0 <= w_req_off[MIDX-1:0];
                            r_len  <= w_req_len;
                            // Beat 0 moves at this edge, so the next beat is 1.
                            r_beat <= 5'd1;
                            if (!bus.rw) begin
                                r_state      <= ST_RD;
                                r_busy       <= 1'b1;
                                r_data_valid <= 1'b1;
                                r_data_out   <= w_rd_data;
                            end else if (w_req_len != 5'd1) begin
                                r_state <= ST_WR;
                                r_busy  <= 1'b1;
                            end
                        end
                    end
                end
                ST_RD: begin
                    if (r_beat == r_len) begin
                        // Last beat was shown in the cycle just ended.
                        r_state      <= ST_IDLE;
                        r_busy       <= 1'b0;
                        r_data_valid <= 1'b0;
                    end else begin
                        r_data_out   <= w_rd_data;
                        r_data_valid <= 1'b1;
                        r_beat       <= r_beat + 5'd1;
                    end
                end
                ST_WR: begin
                    if (r_beat == (r_len - 5'd1)) begin
                        // This edge writes the final beat.
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_beat <= r_beat + 5'd1;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_busy       <= 1'b0;
                    r_data_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.data_valid = r_data_valid;
    assign bus.error      = r_error;
    assign bus.data_out   = r_data_out;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_burst_memory.sv
// tb_burst_memory: directed and randomized bursts against a word-level
// reference memory, with beat addresses computed arithmetically from the
// burst rules (incrementing or critical-word-first wrap).
module tb_burst_memory;

    localparam int          DW    = 32;
    localparam int          AW    = 32;
    localparam int          DEPTH = 1048576;
    localparam logic [31:0] START = 32'h80020000;
`ifdef BURST_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic       clock;
    logic       reset;
    logic [1:0] dbg_state;

    int n_tests;
    int n_fail;

    logic [31:0] mdl [longint];     // reference contents keyed by byte offset
    logic [31:0] wdata [16];        // beats for the next write burst
    logic [31:0] rd_seen [16];      // beats seen by the last read burst

    burst_memory_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    burst_memory #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH_BYTES(DEPTH),
        .START_ADDR (START)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .o_dbg_state(dbg_state)
    );

    // Clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int len_of(input logic [1:0] sz);
        case (sz)
            2'b00:   return 1;
            2'b01:   return 4;
            2'b10:   return 8;
            default: return 16;
        endcase
    endfunction

    // Byte offset of beat k of a burst of L words starting at offset o0.
    function automatic longint exp_off(input longint o0, input int L, input int k);
        longint span;
        longint base;
        span = longint'(L) * 4;
        if (WRAP) begin
            base = (o0 / span) * span;
            return base + ((o0 - base + 4 * longint'(k)) % span);
        end
        return o0 + 4 * longint'(k);
    endfunction

    function automatic logic [31:0] mdl_read(input longint off);
        if (mdl.exists(off)) return mdl[off];
        return 'x;
    endfunction

    // Request fields are don't-care while busy; keep them moving.
    task automatic scramble();
        bus.enable      = 1'($urandom_range(0, 1));
        bus.address     = $urandom;
        bus.rw          = 1'($urandom_range(0, 1));
        bus.access_size = 2'($urandom_range(0, 3));
        bus.data_in     = $urandom;
    endtask

    // One complete request, checked cycle by cycle. abort_at >= 0 asserts
    // reset during beat abort_at of a read, or before the edge that would
    // sample beat abort_at of a write.
    task automatic run_req(input logic [31:0] addr, input logic [1:0] sz,
                           input logic wr, input int abort_at, input string tag);
        int          L;
        logic [31:0] off;
        bit          bad;
        logic [31:0] last;
        L    = len_of(sz);
        off  = (addr - START) & ~32'h3;
        bad  = (longint'(off) >= longint'(DEPTH)) ||
               (!WRAP && (longint'(off) + longint'(L) * 4 > longint'(DEPTH)));
        last = 'x;
        bus.address     = addr;
        bus.access_size = sz;
        bus.rw          = wr;
        bus.enable      = 1'b1;
        bus.data_in     = wdata[0];
        @(posedge clock); #1;
        bus.enable = 1'b0;
        if (bad) begin
            check_val({tag, "_err_pulse"}, 32'(bus.error), 32'd1);
            check_val({tag, "_err_busy"}, 32'(bus.busy), 32'd0);
            check_val({tag, "_err_dv"}, 32'(bus.data_valid), 32'd0);
            @(posedge clock); #1;
            check_val({tag, "_err_clear"}, 32'(bus.error), 32'd0);
            check_val({tag, "_err_busy2"}, 32'(bus.busy), 32'd0);
            return;
        end
        check_val({tag, "_no_err"}, 32'(bus.error), 32'd0);
        if (!wr) begin
            for (int k = 0; k < L; k++) begin
                last = mdl_read(exp_off(longint'(off), L, k));
                rd_seen[k] = bus.data_out;
                check_val($sformatf("%s_rd_busy%0d", tag, k), 32'(bus.busy), 32'd1);
                check_val($sformatf("%s_rd_dv%0d", tag, k), 32'(bus.data_valid), 32'd1);
                check_val($sformatf("%s_rd_data%0d", tag, k), bus.data_out, last);
                scramble();
                if (k == abort_at) reset = 1'b1;
                @(posedge clock); #1;
                bus.enable = 1'b0;
                if (k == abort_at) begin
                    reset = 1'b0;
                    check_val({tag, "_abort_dv"}, 32'(bus.data_valid), 32'd0);
                    check_val({tag, "_abort_busy"}, 32'(bus.busy), 32'd0);
                    check_val({tag, "_abort_dout"}, bus.data_out, 32'd0);
                    return;
                end
            end
            check_val({tag, "_rd_end_busy"}, 32'(bus.busy), 32'd0);
            check_val({tag, "_rd_end_dv"}, 32'(bus.data_valid), 32'd0);
            check_val({tag, "_rd_hold"}, bus.data_out, last);
        end else begin
            mdl[exp_off(longint'(off), L, 0)] = wdata[0];
            for (int k = 1; k < L; k++) begin
                check_val($sformatf("%s_wr_busy%0d", tag, k), 32'(bus.busy), 32'd1);
                check_val($sformatf("%s_wr_dv%0d", tag, k), 32'(bus.data_valid), 32'd0);
                scramble();
                if (k == abort_at) begin
                    reset = 1'b1;
                    @(posedge clock); #1;
                    bus.enable = 1'b0;
                    reset = 1'b0;
                    check_val({tag, "_wabort_busy"}, 32'(bus.busy), 32'd0);
                    return;
                end
                bus.data_in = wdata[k];
                @(posedge clock); #1;
                bus.enable = 1'b0;
                mdl[exp_off(longint'(off), L, k)] = wdata[k];
            end
            check_val({tag, "_wr_end_busy"}, 32'(bus.busy), 32'd0);
            check_val({tag, "_wr_end_dv"}, 32'(bus.data_valid), 32'd0);
        end
    endtask

    task automatic fill_random();
        for (int k = 0; k < 16; k++) wdata[k] = $urandom;
    endtask

    initial begin
        logic [31:0] wrap_exp [4];
        logic [31:0] addr;
        int          sel;

        n_tests = 0;
        n_fail  = 0;

        // Reset with the clock running.
        reset           = 1'b1;
        bus.enable      = 1'b0;
        bus.address     = '0;
        bus.data_in     = '0;
        bus.rw          = 1'b0;
        bus.access_size = 2'b00;
        repeat (3) @(posedge clock);
        #1;
        check_val("rst_busy", 32'(bus.busy), 32'd0);
        check_val("rst_dv", 32'(bus.data_valid), 32'd0);
        check_val("rst_err", 32'(bus.error), 32'd0);
        check_val("rst_dout", bus.data_out, 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        // Single-word write then read at the storage base.
        wdata[0] = 32'hDEADBEEF;
        run_req(START, 2'b00, 1'b1, -1, "w1");
        run_req(START, 2'b00, 1'b0, -1, "r1");
        check_val("r1_deadbeef", rd_seen[0], 32'hDEADBEEF);

        // 4-word write 1..4 then read back, issued as soon as busy falls.
        for (int k = 0; k < 4; k++) wdata[k] = 32'(k + 1);
        run_req(32'h80020010, 2'b01, 1'b1, -1, "w4");
        run_req(32'h80020010, 2'b01, 1'b0, -1, "r4");
        for (int k = 0; k < 4; k++) check_val($sformatf("r4_val%0d", k), rd_seen[k], 32'(k + 1));
        run_req(START, 2'b00, 1'b0, -1, "r1b");

        // Prefill a low window and the top of storage.
        for (int o = 0; o < 'h500; o += 64) begin
            fill_random();
            run_req(START + 32'(o), 2'b11, 1'b1, -1, "pre_lo");
        end
        for (int o = DEPTH - 256; o < DEPTH; o += 64) begin
            fill_random();
            run_req(START + 32'(o), 2'b11, 1'b1, -1, "pre_hi");
        end

        // Range boundaries.
        run_req(START + 32'(DEPTH) - 32'd16, 2'b10, 1'b0, -1, "bnd_r8");
        run_req(32'h80000000, 2'b00, 1'b0, -1, "below_base");
        run_req(START + 32'(DEPTH) - 32'd16, 2'b01, 1'b0, -1, "bnd_r4_fit");
        run_req(START + 32'(DEPTH) - 32'd12, 2'b01, 1'b0, -1, "bnd_r4_over");
        run_req(START + 32'(DEPTH) - 32'd4, 2'b00, 1'b0, -1, "bnd_last");
        run_req(START + 32'(DEPTH), 2'b00, 1'b0, -1, "bnd_past");
        wdata[0] = 32'h0BAD0BAD;
        run_req(START + 32'(DEPTH) - 32'd8, 2'b01, 1'b1, -1, "bnd_w4_over");
        run_req(START + 32'(DEPTH) - 32'd8, 2'b00, 1'b0, -1, "bnd_w_chk");

        // Burst order: words hold their own offsets.
        for (int k = 0; k < 4; k++) wdata[k] = 32'h10 + 32'(4 * k);
        run_req(32'h80020010, 2'b01, 1'b1, -1, "ord_w0");
        for (int k = 0; k < 4; k++) wdata[k] = 32'h20 + 32'(4 * k);
        run_req(32'h80020020, 2'b01, 1'b1, -1, "ord_w1");
        run_req(32'h80020018, 2'b01, 1'b0, -1, "ord_r");
        if (WRAP) begin
            wrap_exp[0] = 32'h18; wrap_exp[1] = 32'h1C; wrap_exp[2] = 32'h10; wrap_exp[3] = 32'h14;
        end else begin
            wrap_exp[0] = 32'h18; wrap_exp[1] = 32'h1C; wrap_exp[2] = 32'h20; wrap_exp[3] = 32'h24;
        end
        for (int k = 0; k < 4; k++) check_val($sformatf("ord_beat%0d", k), rd_seen[k], wrap_exp[k]);

        // Reset in the middle of bursts.
        run_req(32'h80020100, 2'b11, 1'b0, 5, "abort_rd");
        fill_random();
        run_req(32'h80020200, 2'b11, 1'b1, 6, "abort_wr");
        run_req(32'h80020200, 2'b11, 1'b0, -1, "abort_wr_chk");

        // Randomized traffic.
        for (int t = 0; t < 60; t++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 6) begin
                addr = START + 32'($urandom_range(0, 'h3C0)) ;
            end else if (sel <= 8) begin
                addr = START + 32'(DEPTH) - 32'($urandom_range(1, 64) * 4);
            end else if ($urandom_range(0, 1) == 0) begin
                addr = START + 32'(DEPTH) + 32'($urandom_range(0, 255) * 4);
            end else begin
                addr = START - 32'($urandom_range(1, 255) * 4);
            end
            fill_random();
            run_req(addr, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), -1,
                    $sformatf("rnd%0d", t));
        end

        // Read back the low window through the reference.
        for (int o = 0; o < 'h400; o += 64) begin
            run_req(START + 32'(o), 2'b11, 1'b0, -1, "final_rd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
